// File: rtl/branch_stall_unit.sv
// Branch operand hazard detector for the decode stage.
// Tracks the E- and M-stage producers and stalls a branch/jalr in decode until
// its sources can be forwarded, inserting a bubble into ID/EX for each stall cycle.
// Also keeps a saturating count of stall cycles for performance monitoring.
module branch_stall_unit #(
   parameter int unsigned          REG_LOGSIZE = 5,
   parameter int unsigned          CNT_W       = 16,
   parameter int unsigned          OPCODE_W    = 7,
   parameter logic [OPCODE_W-1:0]  LOAD_OP     = 7'b0000011,
   parameter logic [OPCODE_W-1:0]  BTYPE_OP    = 7'b1100011,
   parameter logic [OPCODE_W-1:0]  JALR_OP     = 7'b1100111
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [OPCODE_W-1:0]    opcode,
   input  logic [REG_LOGSIZE-1:0] rs1_field,
   input  logic [REG_LOGSIZE-1:0] rs2_field,
   input  logic [REG_LOGSIZE-1:0] wr_field,
   input  logic                   wr_en,
   input  logic                   freeze,
   output logic                   stall,
   output logic                   bubble,
   output logic [CNT_W-1:0]       stall_cnt
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   // Tracker entries: p1 = E stage, p2 = M stage
   logic                   p1_vld_q, p1_vld_d, p1_ld_q, p1_ld_d;
   logic [REG_LOGSIZE-1:0] p1_rd_q, p1_rd_d;
   logic                   p2_vld_q, p2_vld_d, p2_ld_q, p2_ld_d;
   logic [REG_LOGSIZE-1:0] p2_rd_q, p2_rd_d;
   logic [0:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic is_load, is_br, is_jalr, use_rs1, use_rs2, dec_vld;
   logic hit1, hit2, stall_int;

   // Decode classification and hazard detection
   always_comb begin
      is_load = (opcode == LOAD_OP);
      is_br   = (opcode == BTYPE_OP);
      is_jalr = (opcode == JALR_OP);
      use_rs1 = is_br || is_jalr;
      use_rs2 = is_br;
      // x0 is never a real producer
      dec_vld = wr_en && (wr_field != '0);
      hit1 = p1_vld_q &&
             ((use_rs1 && (p1_rd_q == rs1_field)) || (use_rs2 && (p1_rd_q == rs2_field)));
      hit2 = p2_vld_q && p2_ld_q &&
             ((use_rs1 && (p2_rd_q == rs1_field)) || (use_rs2 && (p2_rd_q == rs2_field)));
      stall_int = use_rs1 && (hit1 || hit2) && !freeze && !rst;
   end

   assign stall     = stall_int;
   assign bubble    = stall_int;
   assign stall_cnt = cnt_q;

   // Next-state for tracker shift, status FSM and saturating counter
   always_comb begin
      p1_vld_d = p1_vld_q;
      p1_rd_d  = p1_rd_q;
      p1_ld_d  = p1_ld_q;
      p2_vld_d = p2_vld_q;
      p2_rd_d  = p2_rd_q;
      p2_ld_d  = p2_ld_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      if (!freeze) begin
         p2_vld_d = p1_vld_q;
         p2_rd_d  = p1_rd_q;
         p2_ld_d  = p1_ld_q;
         if (stall_int) begin
            p1_vld_d = 1'b0;
            p1_rd_d  = '0;
            p1_ld_d  = 1'b0;
         end else begin
            p1_vld_d = dec_vld;
            p1_rd_d  = wr_field;
            p1_ld_d  = is_load;
         end
         state_d = stall_int ? WAIT : RUN;
      end
      if (stall_int && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset; reset drops any in-flight hazard
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_vld_q <= 1'b0;
         p1_rd_q  <= '0;
         p1_ld_q  <= 1'b0;
         p2_vld_q <= 1'b0;
         p2_rd_q  <= '0;
         p2_ld_q  <= 1'b0;
         state_q  <= RUN;
         cnt_q    <= '0;
      end else begin
         p1_vld_q <= p1_vld_d;
         p1_rd_q  <= p1_rd_d;
         p1_ld_q  <= p1_ld_d;
         p2_vld_q <= p2_vld_d;
         p2_rd_q  <= p2_rd_d;
         p2_ld_q  <= p2_ld_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_stall_unit.sv
// Scoreboard bench for branch_stall_unit: a directed driver pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_branch_stall_unit;

   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_ALU  = 7'b0110011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst, freeze, wr_en;
   logic [6:0]  opcode;
   logic [4:0]  rs1_field, rs2_field, wr_field;
   logic        stall, bubble, stall_s, bubble_s;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt_s;

   typedef struct {
      logic        chk;
      logic        stall;
      logic [15:0] cnt;
      logic [1:0]  cnt_s;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   branch_stall_unit #(.REG_LOGSIZE(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .rs1_field(rs1_field), .rs2_field(rs2_field),
      .wr_field(wr_field), .wr_en(wr_en), .freeze(freeze),
      .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
   );

   branch_stall_unit #(.REG_LOGSIZE(5), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .opcode(opcode), .rs1_field(rs1_field), .rs2_field(rs2_field),
      .wr_field(wr_field), .wr_en(wr_en), .freeze(freeze),
      .stall(stall_s), .bubble(bubble_s), .stall_cnt(stall_cnt_s)
   );

   // Drive one decode cycle and record what the outputs must be during it
   task automatic step(input logic r, input logic f, input logic [6:0] op,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                       input logic we, input logic es, input int ec);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; freeze = f; opcode = op;
      rs1_field = s1; rs2_field = s2; wr_field = rd; wr_en = we;
      e.chk   = 1'b1;
      e.stall = es;
      e.cnt   = 16'(ec);
      e.cnt_s = (ec > 3) ? 2'd3 : 2'(ec);
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: compare every expected cycle away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               cmp("stall", int'(stall), int'(e.stall));
               cmp("bubble", int'(bubble), int'(e.stall));
               cmp("stall_cnt", int'(stall_cnt), int'(e.cnt));
               cmp("stall_cnt_sat2", int'(stall_cnt_s), int'(e.cnt_s));
               cmp("stall_sat2", int'(stall_s), int'(e.stall));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; opcode = OP_IMM;
      rs1_field = '0; rs2_field = '0; wr_field = '0; wr_en = 1'b0;
      @(posedge clk);
      //    rst frz op       rs1 rs2 rd we  stall cnt
      step(1, 0, OP_IMM,  0, 0, 0, 0, 0, 0);
      // addi x1 ; beq x1,x5 -> one stall
      step(0, 0, OP_IMM,  0, 0, 1, 1, 0, 0);
      step(0, 0, OP_BR,   1, 5, 0, 0, 1, 0);
      step(0, 0, OP_BR,   1, 5, 0, 0, 0, 1);
      // lw x3 ; beq x3,x0 -> two stalls
      step(0, 0, OP_LOAD, 0, 0, 3, 1, 0, 1);
      step(0, 0, OP_BR,   3, 0, 0, 0, 1, 1);
      step(0, 0, OP_BR,   3, 0, 0, 0, 1, 2);
      step(0, 0, OP_BR,   3, 0, 0, 0, 0, 3);
      // lw x3 ; nop ; beq x4,x3 -> one stall
      step(0, 0, OP_LOAD, 0, 0, 3, 1, 0, 3);
      step(0, 0, OP_IMM,  0, 0, 0, 1, 0, 3);
      step(0, 0, OP_BR,   4, 3, 0, 0, 1, 3);
      step(0, 0, OP_BR,   4, 3, 0, 0, 0, 4);
      // addi x3 ; nop ; beq x4,x3 -> no stall
      step(0, 0, OP_IMM,  0, 0, 3, 1, 0, 4);
      step(0, 0, OP_IMM,  0, 0, 0, 1, 0, 4);
      step(0, 0, OP_BR,   4, 3, 0, 0, 0, 4);
      // addi x0 ; beq x0,x0 -> no stall
      step(0, 0, OP_IMM,  0, 0, 0, 1, 0, 4);
      step(0, 0, OP_BR,   0, 0, 0, 0, 0, 4);
      // addi x7 ; add x8,x7,x7 -> non-branch never stalls
      step(0, 0, OP_IMM,  0, 0, 7, 1, 0, 4);
      step(0, 0, OP_ALU,  7, 7, 8, 1, 0, 4);
      // jalr ignores rs2: rs2 field matches x8 in E, no stall
      step(0, 0, OP_JALR, 2, 8, 0, 1, 0, 4);
      // addi x9 ; jalr x9 -> one stall
      step(0, 0, OP_IMM,  0, 0, 9, 1, 0, 4);
      step(0, 0, OP_JALR, 9, 0, 0, 1, 1, 4);
      step(0, 0, OP_JALR, 9, 0, 0, 1, 0, 5);
      // lw x3 ; beq x3 frozen 3 cycles, then two stalls
      step(0, 0, OP_LOAD, 0, 0, 3, 1, 0, 5);
      step(0, 1, OP_BR,   3, 0, 0, 0, 0, 5);
      step(0, 1, OP_BR,   3, 0, 0, 0, 0, 5);
      step(0, 1, OP_BR,   3, 0, 0, 0, 0, 5);
      step(0, 0, OP_BR,   3, 0, 0, 0, 1, 5);
      step(0, 0, OP_BR,   3, 0, 0, 0, 1, 6);
      step(0, 0, OP_BR,   3, 0, 0, 0, 0, 7);
      // reset in the middle of a load-use stall drops the hazard
      step(0, 0, OP_LOAD, 0, 0, 3, 1, 0, 7);
      step(0, 0, OP_BR,   3, 0, 0, 0, 1, 7);
      step(1, 0, OP_BR,   3, 0, 0, 0, 0, 8);
      step(0, 0, OP_BR,   3, 0, 0, 0, 0, 0);
      // lw x5 ; addi x6 ; beq x5,x6 -> hit1 and hit2 together, counted once
      step(0, 0, OP_LOAD, 0, 0, 5, 1, 0, 0);
      step(0, 0, OP_IMM,  0, 0, 6, 1, 0, 0);
      step(0, 0, OP_BR,   5, 6, 0, 0, 1, 0);
      step(0, 0, OP_BR,   5, 6, 0, 0, 0, 1);
      step(0, 0, OP_IMM,  0, 0, 0, 1, 0, 1);
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
